ad7609_ctrl: RTL and testbench
==============================

# ad7609_ctrl

Conversion and serial-readout controller for the AD7609 8-channel simultaneous-sampling ADC. It sits directly upstream of the APB register block: its `Start` input is that block's `Start` output, and its `value1`..`value8` outputs drive that block's channel inputs. On request it pulses CONVST, waits out BUSY, and shifts 2×72 bits in on DOUTA/DOUTB. It then updates all eight channel registers in the same cycle.

## Interface
Parameters:
- `CLK_DIV`, default 2: clk_i cycles per SCLK half-period (≥1).
- `CONVST_LOW_CYC`, default 4: CONVST low pulse width in clk_i cycles.
- `RESET_CYC`, default 10: ADC RESET pulse width after reset release.
- `BUSY_TIMEOUT`, default 2000: maximum cycles to wait for each BUSY edge.

Ports:
- `clk_i`, in, 1: system clock. This is the only clock.
- `rst_n_i`, in, 1: reset, asynchronous and active-low.
- `Start`, in, 1: conversion request, level from the APB block.
- `busy_i`, in, 1: AD7609 BUSY, asynchronous to clk_i.
- `douta_i` / `doutb_i`, in, 1 each: AD7609 DOUTA (CH1–4) and DOUTB (CH5–8).
- `convst_o`, out, 1: CONVSTA/B (tied together), idle high.
- `cs_n_o`, out, 1: chip select, idle high.
- `sclk_o`, out, 1: serial clock, idle high.
- `adc_reset_o`, out, 1: AD7609 RESET, active high.
- `value1`..`value8`, out, 16 each: latest channel results.
- `data_valid_o`, out, 1: one-cycle pulse when the values update.
- `timeout_o`, out, 1: one-cycle pulse on a BUSY timeout.

## Operation
- Reset values:
  - `convst_o`=1, `cs_n_o`=1, `sclk_o`=1.
  - `adc_reset_o`=1.
  - All values=0.
  - `data_valid_o`=0, `timeout_o`=0.
  - State is RST_ADC.
- `busy_i` passes through a 2-FF synchronizer. All BUSY decisions use the synchronized copy.
- `Start` is registered. A request is a rising edge (0→1) of the registered Start.
- States:
  - RST_ADC: hold `adc_reset_o`=1 for RESET_CYC cycles, then drive 0 and go to IDLE.
  - IDLE: on a request, go to CONV.
  - CONV: `convst_o`=0 for CONVST_LOW_CYC cycles, then 1, then go to WAIT_BH.
  - WAIT_BH: wait for busy=1, then go to WAIT_BL. If the count reaches BUSY_TIMEOUT first, pulse `timeout_o` and go to IDLE.
  - WAIT_BL: wait for busy=0, then go to READ. The timeout rule is the same as WAIT_BH.
  - READ: `cs_n_o`=0 and 72 SCLK periods (detail below), then go to DONE.
  - DONE: `cs_n_o`=1, latch all eight values, pulse `data_valid_o`, then go to IDLE.
- Serial capture:
  - SCLK runs low CLK_DIV cycles, then high CLK_DIV cycles.
  - `douta_i`/`doutb_i` are sampled in the cycle `sclk_o` goes 0→1 and shifted MSB-first into two 72-bit shift registers.
  - The first falling edge occurs CLK_DIV cycles after `cs_n_o` falls.
- Arithmetic:
  - Each channel is an 18-bit two's-complement word. CH1 is the first 18 bits on DOUTA; CH5 is the first 18 bits on DOUTB.
  - Output = word[17:2], truncated with no rounding.
- Requests arriving in any state other than IDLE are ignored and are not queued.
- On a timeout, values are left unchanged and no `data_valid_o` pulse is issued.
- An async reset mid-conversion aborts immediately to the reset values. The ADC reset sequence reruns.

## Timing
- Request latency: a Start 0→1 at the input gives `convst_o` low 2 cycles later (input register plus edge detect).
- Readout: `cs_n_o` low for 72×2×CLK_DIV + CLK_DIV cycles.
- Update: `data_valid_o` and the new values appear together, 1 cycle after `cs_n_o` rises.
- Values are stable between `data_valid_o` pulses. All eight channels change in the same cycle.
- BUSY path: each BUSY edge is seen by the FSM 2–3 cycles after it occurs on the pin.

## Configuration
- `AD7609_CONTINUOUS_EN`:
  - Defined: in DONE, if registered Start is still 1, go directly to CONV instead of IDLE. Conversions repeat back-to-back while Start is held high, and a timeout still returns to IDLE.
  - Undefined: one conversion per Start rising edge only.

## Test plan
- **Reset:** release `rst_n_i` → `adc_reset_o` high for exactly 10 cycles, then 0. All other outputs are at their reset values.
- **Single conversion:** ADC model returns CH1=18'h1FFFF, CH4=18'h20000, CH5=18'h00004, CH8=18'h3FFFF, with BUSY high for 200 cycles.
  - `value1`=16'h7FFF, `value4`=16'h8000, `value5`=16'h0001, `value8`=16'hFFFF.
  - One `data_valid_o` pulse. `cs_n_o` low for 290 cycles (CLK_DIV=2).
- **Start during READ:** toggle Start 0→1→0 mid-readout → no second CONVST and exactly one `data_valid_o`.
- **BUSY stuck low:** → `timeout_o` pulses BUSY_TIMEOUT cycles after CONVST rises. Values are unchanged, the FSM is in IDLE, and the next request works normally.
- **Reset mid-READ:** → `cs_n_o`=1 and `sclk_o`=1 immediately, values=0, and RST_ADC reruns.
- **Continuous mode:** with `AD7609_CONTINUOUS_EN` defined, hold Start=1 → ≥3 back-to-back `data_valid_o` pulses. Drop Start → the conversion in progress completes, then the FSM returns to IDLE.

Source files
------------

// File: rtl/ad7609_ctrl.sv
`timescale 1ns/1ps
// ad7609_ctrl
// ---------------------------------------------------------------------------
// Conversion and serial-readout controller for the AD7609 8-channel
// simultaneous-sampling ADC. A rising edge on the registered Start level
// pulses CONVST. The FSM then waits for BUSY to rise and fall, shifts
// 2 x 72 bits in on DOUTA/DOUTB and updates all eight channel outputs in
// one cycle.
//
// Optional feature macro: AD7609_CONTINUOUS_EN
//   defined   : DONE goes straight back to CONV while registered Start is
//               still high, so conversions run back-to-back.
//   undefined : one conversion per Start rising edge.
//
// Ports
//   clk_i         in   system clock (only clock)
//   rst_n_i       in   asynchronous active-low reset
//   Start         in   conversion request level (rising edge = request)
//   busy_i        in   AD7609 BUSY, asynchronous, 2-FF synchronized here
//   douta_i       in   AD7609 DOUTA (CH1..CH4)
//   doutb_i       in   AD7609 DOUTB (CH5..CH8)
//   convst_o      out  CONVSTA/B, idle high
//   cs_n_o        out  chip select, idle high
//   sclk_o        out  serial clock, idle high
//   adc_reset_o   out  AD7609 RESET, active high
//   value1..8     out  latest 16-bit channel results (18-bit word [17:2])
//   data_valid_o  out  one-cycle pulse when value1..8 update
//   timeout_o     out  one-cycle pulse on a BUSY timeout
//   state_o       out  current FSM state (debug observation)
//
// Handshake: data_valid_o is a single-cycle strobe with no ready/backpressure.
// value1..8 change only in the cycle data_valid_o is high and hold otherwise,
// so a consumer may capture on the strobe or read the values at any time.
// ---------------------------------------------------------------------------
module ad7609_ctrl #(
  parameter int unsigned CLK_DIV        = 2,
  parameter int unsigned CONVST_LOW_CYC = 4,
  parameter int unsigned RESET_CYC      = 10,
  parameter int unsigned BUSY_TIMEOUT   = 2000
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        Start,
  input  logic        busy_i,
  input  logic        douta_i,
  input  logic        doutb_i,
  output logic        convst_o,
  output logic        cs_n_o,
  output logic        sclk_o,
  output logic        adc_reset_o,
  output logic [15:0] value1,
  output logic [15:0] value2,
  output logic [15:0] value3,
  output logic [15:0] value4,
  output logic [15:0] value5,
  output logic [15:0] value6,
  output logic [15:0] value7,
  output logic [15:0] value8,
  output logic        data_valid_o,
  output logic        timeout_o,
  output logic [2:0]  state_o
);

  // FSM state encoding
  localparam logic [2:0] S_RST_ADC = 3'd0;
  localparam logic [2:0] S_IDLE    = 3'd1;
  localparam logic [2:0] S_CONV    = 3'd2;
  localparam logic [2:0] S_WAIT_BH = 3'd3;
  localparam logic [2:0] S_WAIT_BL = 3'd4;
  localparam logic [2:0] S_READ    = 3'd5;
  localparam logic [2:0] S_DONE    = 3'd6;

  // One shared cycle counter serves RST_ADC, CONV and both BUSY waits, so it
  // is sized for the largest of the three limits.
  localparam int unsigned CNT_MAX_A = (RESET_CYC > CONVST_LOW_CYC) ? RESET_CYC : CONVST_LOW_CYC;
  localparam int unsigned CNT_MAX   = (CNT_MAX_A > BUSY_TIMEOUT) ? CNT_MAX_A : BUSY_TIMEOUT;
  localparam int unsigned CNT_W     = $clog2(CNT_MAX + 1);
  localparam int unsigned DIV_W     = $clog2(CLK_DIV + 1);

  localparam logic [CNT_W-1:0] RESET_LAST  = CNT_W'(RESET_CYC - 1);
  localparam logic [CNT_W-1:0] CONVST_LAST = CNT_W'(CONVST_LOW_CYC - 1);
  localparam logic [CNT_W-1:0] BUSY_LAST   = CNT_W'(BUSY_TIMEOUT - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);
  localparam logic [6:0]       NUM_BITS    = 7'd72;

  logic [2:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [DIV_W-1:0] r_div;
  logic [6:0]       r_bitcnt;

  logic             r_busy_s1;
  logic             r_busy_s2;
  logic             r_start_q;
  logic             r_start_qq;
  logic             w_req;

  logic             r_convst;
  logic             r_cs_n;
  logic             r_sclk;
  logic             r_adc_reset;
  logic             r_dv;
  logic             r_timeout;

  logic [71:0]      r_sha;
  logic [71:0]      r_shb;
  logic [15:0]      r_val [8];

  // BUSY synchronizer and Start edge detector. These run in every state;
  // only IDLE consumes w_req, so requests elsewhere are simply dropped.
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_busy_s1  <= 1'b0;
      r_busy_s2  <= 1'b0;
      r_start_q  <= 1'b0;
      r_start_qq <= 1'b0;
    end else begin
      r_busy_s1  <= busy_i;
      r_busy_s2  <= r_busy_s1;
      r_start_q  <= Start;
      r_start_qq <= r_start_q;
    end
  end

  assign w_req = r_start_q & ~r_start_qq;

  // Main control FSM
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state     <= S_RST_ADC;
      r_cnt       <= '0;
      r_div       <= '0;
      r_bitcnt    <= '0;
      r_convst    <= 1'b1;
      r_cs_n      <= 1'b1;
      r_sclk      <= 1'b1;
      r_adc_reset <= 1'b1;
      r_dv        <= 1'b0;
      r_timeout   <= 1'b0;
      r_sha       <= '0;
      r_shb       <= '0;
      for (int i = 0; i < 8; i++) begin
        r_val[i] <= '0;
      end
    end else begin
      r_dv      <= 1'b0;
      r_timeout <= 1'b0;
      case (r_state)
        S_RST_ADC: begin
          if (r_cnt == RESET_LAST) begin
            r_adc_reset <= 1'b0;
            r_cnt       <= '0;
            r_state     <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_IDLE: begin
          if (w_req) begin
            r_convst <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_CONV;
          end
        end

        S_CONV: begin
          if (r_cnt == CONVST_LAST) begin
            r_convst <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_WAIT_BH;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_WAIT_BH: begin
          if (r_busy_s2) begin
            r_cnt   <= '0;
            r_state <= S_WAIT_BL;
          end else if (r_cnt == BUSY_LAST) begin
            r_timeout <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        S_WAIT_BL: begin
          if (!r_busy_s2) begin
            r_cs_n   <= 1'b0;
            r_div    <= '0;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_state  <= S_READ;
          end else if (r_cnt == BUSY_LAST) begin
            r_timeout <= 1'b1;
            r_cnt     <= '0;
            r_state   <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end

        // SCLK idles high; the first half-period after CS falls is a high
        // lead-in, then 72 low/high periods. The slot where the 73rd falling
        // edge would land releases CS instead.
        S_READ: begin
          if (r_div == DIV_LAST) begin
            r_div <= '0;
            if (r_sclk) begin
              if (r_bitcnt == NUM_BITS) begin
                r_cs_n  <= 1'b1;
                r_state <= S_DONE;
              end else begin
                r_sclk <= 1'b0;
              end
            end else begin
              // Data is sampled in the cycle SCLK goes 0->1, MSB first.
              r_sclk   <= 1'b1;
              r_sha    <= {r_sha[70:0], douta_i};
              r_shb    <= {r_shb[70:0], doutb_i};
              r_bitcnt <= r_bitcnt + 7'd1;
            end
          end else begin
            r_div <= r_div + DIV_W'(1);
          end
        end

        // Each channel is an 18-bit word; the output keeps bits [17:2]
        // (truncation, no rounding). CH1/CH5 arrive first, so they sit at the
        // top of each shift register.
        S_DONE: begin
          for (int i = 0; i < 4; i++) begin
            r_val[i]     <= r_sha[71 - 18*i -: 16];
            r_val[i + 4] <= r_shb[71 - 18*i -: 16];
          end
          r_dv <= 1'b1;
`ifdef AD7609_CONTINUOUS_EN
          if (r_start_q) begin
            r_convst <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_CONV;
          end else begin
            r_state <= S_IDLE;
          end
`else
          r_state <= S_IDLE;
`endif
        end

        default: begin
          r_convst <= 1'b1;
          r_cs_n   <= 1'b1;
          r_sclk   <= 1'b1;
          r_cnt    <= '0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign convst_o     = r_convst;
  assign cs_n_o       = r_cs_n;
  assign sclk_o       = r_sclk;
  assign adc_reset_o  = r_adc_reset;
  assign data_valid_o = r_dv;
  assign timeout_o    = r_timeout;
  assign state_o      = r_state;

  assign value1 = r_val[0];
  assign value2 = r_val[1];
  assign value3 = r_val[2];
  assign value4 = r_val[3];
  assign value5 = r_val[4];
  assign value6 = r_val[5];
  assign value7 = r_val[6];
  assign value8 = r_val[7];

endmodule

// File: tb/tb_ad7609_ctrl.sv
`timescale 1ns/1ps
// Testbench for ad7609_ctrl: behavioural AD7609 model (BUSY + serial data),
// scoreboard of expected channel values, directed scenarios.
module tb_ad7609_ctrl;

  localparam logic [2:0] ST_RST_ADC = 3'd0;
  localparam logic [2:0] ST_IDLE    = 3'd1;

  // ---------------- clock / reset ----------------
  logic clk_i = 1'b0;
  logic rst_n_i;
  always #5 clk_i = ~clk_i;

  logic        Start, busy_i, douta_i, doutb_i;
  logic        convst_o, cs_n_o, sclk_o, adc_reset_o;
  logic [15:0] value1, value2, value3, value4, value5, value6, value7, value8;
  logic        data_valid_o, timeout_o;
  logic [2:0]  state_o;

  ad7609_ctrl dut (
    .clk_i(clk_i), .rst_n_i(rst_n_i), .Start(Start), .busy_i(busy_i),
    .douta_i(douta_i), .doutb_i(doutb_i), .convst_o(convst_o), .cs_n_o(cs_n_o),
    .sclk_o(sclk_o), .adc_reset_o(adc_reset_o),
    .value1(value1), .value2(value2), .value3(value3), .value4(value4),
    .value5(value5), .value6(value6), .value7(value7), .value8(value8),
    .data_valid_o(data_valid_o), .timeout_o(timeout_o), .state_o(state_o)
  );

  // ---------------- scoreboard state ----------------
  int           n_vec = 0;
  int           n_err = 0;
  logic [127:0] exp_q[$];
  logic [127:0] cur_vals;
  logic [127:0] last_vals = '0;
  int           dv_count = 0;
  int           to_count = 0;
  int           convst_falls = 0;

  // ---------------- ADC model state ----------------
  logic [71:0]  mdl_a = '0;
  logic [71:0]  mdl_b = '0;
  bit           busy_stuck = 1'b0;
  bit           use_rand = 1'b0;
  int           busy_len = 200;
  int           bit_idx = 0;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [71:0] pack4(input logic [17:0] c1, input logic [17:0] c2,
                                        input logic [17:0] c3, input logic [17:0] c4);
    return {c1, c2, c3, c4};
  endfunction

  // Expected outputs: {value1..value8}, each the 18-bit word's bits [17:2].
  function automatic logic [127:0] exp_of(input logic [71:0] a, input logic [71:0] b);
    logic [127:0] e;
    logic [17:0]  w;
    e = '0;
    for (int i = 0; i < 4; i++) begin
      w = a[71 - 18*i -: 18];
      e[127 - 16*i -: 16] = w[17:2];
      w = b[71 - 18*i -: 18];
      e[63 - 16*i -: 16] = w[17:2];
    end
    return e;
  endfunction

  // ---------------- ADC model ----------------
  // New sample (random if enabled) is taken when CONVST falls.
  initial forever begin
    @(negedge convst_o);
    if (rst_n_i === 1'b1) begin
      convst_falls++;
      if (use_rand) begin
        mdl_a = pack4(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
        mdl_b = pack4(18'($urandom), 18'($urandom), 18'($urandom), 18'($urandom));
      end
    end
  end

  // BUSY rises shortly after CONVST rises, stays high busy_len cycles; the
  // conversion result becomes expected once BUSY falls.
  initial forever begin
    @(posedge convst_o);
    if (rst_n_i === 1'b1 && !busy_stuck) begin
      repeat (2) @(negedge clk_i);
      busy_i = 1'b1;
      repeat (busy_len) @(negedge clk_i);
      busy_i = 1'b0;
      exp_q.push_back(exp_of(mdl_a, mdl_b));
    end
  end

  initial forever begin
    @(negedge cs_n_o);
    bit_idx = 0;
  end

  // Next bit presented on each SCLK falling edge, MSB first.
  initial forever begin
    @(negedge sclk_o);
    if (cs_n_o === 1'b0 && bit_idx < 72) begin
      douta_i = mdl_a[71 - bit_idx];
      doutb_i = mdl_b[71 - bit_idx];
      bit_idx++;
    end
  end

  // ---------------- output monitor ----------------
  initial forever begin
    @(negedge clk_i);
    cur_vals = {value1, value2, value3, value4, value5, value6, value7, value8};
    if (rst_n_i !== 1'b1) begin
      chk("rst_values", cur_vals, 128'h0);
      last_vals = '0;
    end else begin
      if (timeout_o === 1'b1) to_count++;
      if (data_valid_o === 1'b1) begin
        dv_count++;
        if (exp_q.size() == 0) begin
          chk("dv_unexpected", 128'd1, 128'd0);
        end else begin
          logic [127:0] e;
          e = exp_q.pop_front();
          for (int i = 0; i < 8; i++) begin
            chk($sformatf("value%0d", i + 1), cur_vals[127 - 16*i -: 16], e[127 - 16*i -: 16]);
          end
        end
        last_vals = cur_vals;
      end else begin
        chk("values_stable", cur_vals, last_vals);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cs(input logic lvl, input string tag);
    bit found;
    found = 1'b0;
    for (int k = 0; k < 6000; k++) begin
      if (cs_n_o === lvl) begin
        found = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    if (!found) chk(tag, 128'd0, 128'd1);
  endtask

  task automatic release_and_check_reset();
    int n;
    rst_n_i = 1'b1;
    n = 0;
    for (int k = 0; k < 50; k++) begin
      if (adc_reset_o !== 1'b1) break;
      n++;
      @(negedge clk_i);
    end
    chk("adc_reset_len", 128'(n), 128'd10);
    chk("idle_after_reset", 128'(state_o), 128'(ST_IDLE));
    chk("convst_idle", 128'(convst_o), 128'd1);
    chk("cs_idle", 128'(cs_n_o), 128'd1);
    chk("sclk_idle", 128'(sclk_o), 128'd1);
  endtask

  task automatic run_conv(output int lat, output int cs_len);
    @(negedge clk_i);
    Start = 1'b1;
    lat = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk_i);
      lat++;
      if (convst_o === 1'b0) break;
    end
    Start = 1'b0;
    wait_cs(1'b0, "cs_fall_timeout");
    cs_len = 0;
    for (int k = 0; k < 2000; k++) begin
      if (cs_n_o !== 1'b0) break;
      cs_len++;
      @(negedge clk_i);
    end
    chk("dv_at_cs_rise", 128'(data_valid_o), 128'd0);
    @(negedge clk_i);
    chk("dv_after_cs_rise", 128'(data_valid_o), 128'd1);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat, cs_len, dv0, cf0, to0, n;
    logic [127:0] saved;
    bit seen;

    rst_n_i = 1'b0; Start = 1'b0; busy_i = 1'b0; douta_i = 1'b0; doutb_i = 1'b0;
    repeat (3) @(negedge clk_i);

    // Reset values
    chk("rst_convst", 128'(convst_o), 128'd1);
    chk("rst_cs", 128'(cs_n_o), 128'd1);
    chk("rst_sclk", 128'(sclk_o), 128'd1);
    chk("rst_adc_reset", 128'(adc_reset_o), 128'd1);
    chk("rst_dv", 128'(data_valid_o), 128'd0);
    chk("rst_timeout", 128'(timeout_o), 128'd0);
    chk("rst_state", 128'(state_o), 128'(ST_RST_ADC));
    release_and_check_reset();

    // Single conversion with boundary words
    mdl_a = pack4(18'h1FFFF, 18'h0ABCD, 18'h2468A, 18'h20000);
    mdl_b = pack4(18'h00004, 18'h13579, 18'h3C0DE, 18'h3FFFF);
    dv0 = dv_count;
    run_conv(lat, cs_len);
    chk("req_latency", 128'(lat), 128'd2);
    chk("cs_low_len", 128'(cs_len), 128'd290);
    @(negedge clk_i);
    chk("value1_max", 128'(value1), 128'h7FFF);
    chk("value4_min", 128'(value4), 128'h8000);
    chk("value5_small", 128'(value5), 128'h0001);
    chk("value8_neg1", 128'(value8), 128'hFFFF);
    chk("single_dv_count", 128'(dv_count - dv0), 128'd1);

    // Start toggled during READ is ignored
    use_rand = 1'b1;
    dv0 = dv_count; cf0 = convst_falls;
    @(negedge clk_i); Start = 1'b1;
    repeat (4) @(negedge clk_i); Start = 1'b0;
    wait_cs(1'b0, "cs_fall_timeout");
    repeat (50) @(negedge clk_i);
    Start = 1'b1;
    repeat (4) @(negedge clk_i);
    Start = 1'b0;
    wait_cs(1'b1, "cs_rise_timeout");
    repeat (300) @(negedge clk_i);
    chk("read_req_convst", 128'(convst_falls - cf0), 128'd1);
    chk("read_req_dv", 128'(dv_count - dv0), 128'd1);
    chk("read_req_idle", 128'(state_o), 128'(ST_IDLE));

    // BUSY stuck low -> timeout
    busy_stuck = 1'b1;
    dv0 = dv_count; to0 = to_count;
    saved = {value1, value2, value3, value4, value5, value6, value7, value8};
    @(negedge clk_i); Start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (convst_o === 1'b0) begin seen = 1'b1; break; end
    end
    chk("to_convst_fall", 128'(seen), 128'd1);
    Start = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk_i);
      if (convst_o === 1'b1) begin seen = 1'b1; break; end
    end
    chk("to_convst_rise", 128'(seen), 128'd1);
    n = 0;
    for (int k = 0; k < 3000; k++) begin
      if (timeout_o === 1'b1) break;
      n++;
      @(negedge clk_i);
    end
    chk("timeout_delay", 128'(n), 128'd2000);
    @(negedge clk_i);
    chk("timeout_pulse_width", 128'(timeout_o), 128'd0);
    chk("timeout_idle", 128'(state_o), 128'(ST_IDLE));
    chk("timeout_count", 128'(to_count - to0), 128'd1);
    chk("timeout_no_dv", 128'(dv_count - dv0), 128'd0);
    chk("timeout_values", {value1, value2, value3, value4, value5, value6, value7, value8}, saved);
    busy_stuck = 1'b0;
    dv0 = dv_count;
    run_conv(lat, cs_len);
    chk("post_to_latency", 128'(lat), 128'd2);
    chk("post_to_cs_len", 128'(cs_len), 128'd290);
    chk("post_to_dv", 128'(dv_count - dv0), 128'd1);

    // Reset in the middle of READ
    @(negedge clk_i); Start = 1'b1;
    repeat (4) @(negedge clk_i); Start = 1'b0;
    wait_cs(1'b0, "cs_fall_timeout");
    repeat (100) @(negedge clk_i);
    #2;
    rst_n_i = 1'b0;
    exp_q.delete();
    #1;
    chk("mid_rst_cs", 128'(cs_n_o), 128'd1);
    chk("mid_rst_sclk", 128'(sclk_o), 128'd1);
    chk("mid_rst_values", {value1, value2, value3, value4, value5, value6, value7, value8}, 128'h0);
    chk("mid_rst_adc_reset", 128'(adc_reset_o), 128'd1);
    chk("mid_rst_state", 128'(state_o), 128'(ST_RST_ADC));
    repeat (3) @(negedge clk_i);
    release_and_check_reset();
    dv0 = dv_count;
    run_conv(lat, cs_len);
    chk("post_rst_cs_len", 128'(cs_len), 128'd290);
    chk("post_rst_dv", 128'(dv_count - dv0), 128'd1);

`ifdef AD7609_CONTINUOUS_EN
    // Continuous conversions while Start is held
    dv0 = dv_count; cf0 = convst_falls;
    @(negedge clk_i); Start = 1'b1;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk_i);
      if (dv_count - dv0 >= 3) break;
    end
    chk("cont_three_pulses", 128'(dv_count - dv0), 128'd3);
    Start = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk_i);
      if (dv_count - dv0 >= 4) break;
    end
    repeat (300) @(negedge clk_i);
    chk("cont_final_dv", 128'(dv_count - dv0), 128'd4);
    chk("cont_convst", 128'(convst_falls - cf0), 128'd4);
    chk("cont_idle", 128'(state_o), 128'(ST_IDLE));
`endif

    repeat (20) @(negedge clk_i);
    chk("scoreboard_empty", 128'(exp_q.size()), 128'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2ms;
    n_err++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $fatal(1, "watchdog");
  end

endmodule
